pipeline_result_collector: RTL and testbench

Downstream consumer of the three-stage arithmetic pipeline (F = (A+B + C−D)·D, N-bit, 3-cycle latency). The pipeline has no valid tag, so this block delay-matches the upstream issue strobe, captures F only on cycles carrying real results, and reduces fixed-size frames of results to a sum and a maximum. Completed frames leave through a 2-entry valid/ready output queue so a stalled consumer does not back-pressure the free-running pipeline.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/result_fifo2.sv | 64 ++++++
 rtl/pipeline_result_collector.sv | 113 +++++++++++
 tb/tb_pipeline_result_collector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the arithmetic pipeline and its result collector.
package pipeline_pkg;

    localparam int PIPE_N     = 10;
    localparam int PIPE_LAT   = 3;
    localparam int PIPE_FRAME = 8;
    localparam int PIPE_SW    = PIPE_N + $clog2(PIPE_FRAME);

    typedef struct packed {
        logic [PIPE_SW-1:0] sum;
        logic [PIPE_N-1:0]  max;
        logic [7:0]         id;
    } frame_rec_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry record queue; slot0 is always the head, slot1 holds the second record.
module result_fifo2
    import pipeline_pkg::*;
#(
    parameter type rec_t = frame_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  rec_t din_i,
    output rec_t head_o,
    output logic full_o,
    output logic empty_o
);

    q_state_e state_q;
    rec_t     slot0_q;
    rec_t     slot1_q;

    // A push in FULL without a pop is silently dropped; the caller flags it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Q_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            case (state_q)
                Q_EMPTY: begin
                    if (push_i) begin
                        slot0_q <= din_i;
                        state_q <= Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (push_i && pop_i) begin
                        slot0_q <= din_i;
                    end else if (push_i) begin
                        slot1_q <= din_i;
                        state_q <= Q_FULL;
                    end else if (pop_i) begin
                        state_q <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop_i) begin
                        slot0_q <= slot1_q;
                        if (push_i) begin
                            slot1_q <= din_i;
                        end else begin
                            state_q <= Q_ONE;
                        end
                    end
                end
                default: state_q <= Q_EMPTY;
            endcase
        end
    end

    assign head_o  = slot0_q;
    assign full_o  = (state_q == Q_FULL);
    assign empty_o = (state_q == Q_EMPTY);

endmodule

// File: rtl/pipeline_result_collector.sv
// Delay-matches the pipeline issue strobe, reduces frames of results to
// sum/max records and hands them out through a 2-entry valid/ready queue.
module pipeline_result_collector
    import pipeline_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int FRAME = PIPE_FRAME,
    localparam int SW   = N + $clog2(FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  F,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [N-1:0]  out_max,
    output logic [7:0]    out_frame_id,
    output logic          overflow,
    output logic          busy
);

    localparam int CW = $clog2(FRAME);

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [N-1:0]  max;
        logic [7:0]    id;
    } rec_t;

    logic [LAT-1:0] vdl_q, vdl_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  acc_q, acc_d;
    logic [N-1:0]   mx_q, mx_d;
    logic [7:0]     fid_q, fid_d;
    logic           ovf_q, ovf_d;

    logic [LAT:0]   shift_s;
    logic           v_al_s, first_s, last_s, pop_s, full_s, empty_s;
    logic [SW-1:0]  sum_s;
    logic [N-1:0]   max_s;
    rec_t           rec_s, head_s;

    // Next-state for delay line, frame reduction, frame id and sticky overflow.
    always_comb begin
        shift_s = {vdl_q, in_valid};
        vdl_d   = shift_s[LAT-1:0];
        v_al_s  = vdl_q[LAT-1];
        first_s = (cnt_q == '0);
        last_s  = v_al_s && (cnt_q == CW'(FRAME - 1));
        sum_s   = first_s ? SW'(F) : (acc_q + SW'(F));
        max_s   = (first_s || (F > mx_q)) ? F : mx_q;
        pop_s   = out_ready && !empty_s;
        rec_s   = '{sum: sum_s, max: max_s, id: fid_q};

        cnt_d = cnt_q;
        acc_d = acc_q;
        mx_d  = mx_q;
        fid_d = fid_q;
        if (v_al_s) begin
            acc_d = sum_s;
            mx_d  = max_s;
            cnt_d = last_s ? '0 : (cnt_q + CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
        if (last_s) begin
            fid_d = fid_q + 8'd1;
        end else begin
            fid_d = fid_q;
        end
        ovf_d = ovf_q | (last_s && full_s && !pop_s);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdl_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            mx_q  <= '0;
            fid_q <= 8'd0;
            ovf_q <= 1'b0;
        end else begin
            vdl_q <= vdl_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            mx_q  <= mx_d;
            fid_q <= fid_d;
            ovf_q <= ovf_d;
        end
    end

    result_fifo2 #(.rec_t(rec_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (last_s),
        .pop_i   (pop_s),
        .din_i   (rec_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign out_valid    = !empty_s;
    assign out_sum      = head_s.sum;
    assign out_max      = head_s.max;
    assign out_frame_id = head_s.id;
    assign overflow     = ovf_q;
    assign busy         = (|vdl_q) | (cnt_q != '0);

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Scoreboard bench: a behavioural 3-stage pipeline feeds F; expected frame
// records are queued at issue time and checked by an independent monitor.
module tb_pipeline_result_collector;

    localparam int N = 10;
    localparam int LAT = 3;
    localparam int FRAME = 8;
    localparam int SW = 13;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [N-1:0]  max;
        logic [7:0]    id;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  F;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] out_sum;
    logic [N-1:0]  out_max;
    logic [7:0]    out_frame_id;
    logic          overflow;
    logic          busy;

    int opa = 0, opb = 0, opc = 0, opd = 0;
    logic [N-1:0] p0 = '0, p1 = '0, p2 = '0;
    int cyc = 0;
    int last_cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    rec_t sb[$];

    pipeline_result_collector #(.N(N), .LAT(LAT), .FRAME(FRAME)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .F(F),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_max(out_max), .out_frame_id(out_frame_id),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] calc(input int a, input int b, input int c, input int d);
        int r;
        r = (a + b + c - d) * d;
        return r[N-1:0];
    endfunction

    // Free-running model of the upstream pipeline; it is never reset.
    always @(posedge clk) begin
        p0  <= calc(opa, opb, opc, opd);
        p1  <= p0;
        p2  <= p1;
        cyc <= cyc + 1;
    end
    assign F = p2;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted record must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_record: got id %0d sum %0d max %0d expected none",
                         out_frame_id, out_sum, out_max);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("rec_id", out_frame_id, e.id);
                chk("rec_sum", out_sum, e.sum);
                chk("rec_max", out_max, e.max);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int a, input int b, input int c, input int d, input bit v);
        opa = a; opb = b; opc = c; opd = d;
        in_valid = v;
        if (v) last_cyc = cyc;
        tick();
    endtask

    task automatic issue_f(input int f);
        op(f, 0, 1, 1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            op($urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 7), 1'b0);
    endtask

    task automatic expect_rec(input int s, input int m, input int id);
        rec_t e;
        e.sum = SW'(s);
        e.max = N'(m);
        e.id  = 8'(id);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(nm, done, 1);
    endtask

    initial begin
        bit seen;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_frame_id", out_frame_id, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Constant operands, F = 15, back-to-back, with latency measurement.
        expect_rec(120, 15, 0);
        for (int i = 0; i < 8; i++) begin
            op(1, 2, 5, 3, 1'b1);
            if (i == 3) chk("busy_mid_frame", busy, 1);
        end
        op(0, 0, 0, 0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("out_valid_seen", seen, 1);
        chk("latency", cyc - last_cyc, 4);
        drain("drain_t1");
        chk("busy_after_frame", busy, 0);

        // F = 0..7 with idle cycles carrying junk in between.
        do_reset();
        expect_rec(28, 7, 0);
        for (int i = 0; i < 8; i++) begin
            issue_f(i);
            idle(1);
        end
        idle(4);
        drain("drain_t2");

        // Full-scale results.
        do_reset();
        expect_rec(8184, 1023, 0);
        for (int i = 0; i < 8; i++) issue_f(1023);
        idle(4);
        drain("drain_t3");

        // Stalled consumer across three frames: frame 2 is dropped.
        do_reset();
        out_ready = 1'b0;
        expect_rec(8, 1, 0);
        expect_rec(16, 2, 1);
        for (int i = 0; i < 8; i++) issue_f(1);
        for (int i = 0; i < 8; i++) issue_f(2);
        idle(6);
        chk("ovf_before_drop", overflow, 0);
        chk("full_head_id", out_frame_id, 0);
        for (int i = 0; i < 8; i++) issue_f(3);
        idle(6);
        chk("ovf_on_drop", overflow, 1);
        out_ready = 1'b1;
        drain("drain_t4a");
        expect_rec(32, 4, 3);
        for (int i = 0; i < 8; i++) issue_f(4);
        idle(4);
        drain("drain_t4b");
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < 5; i++) issue_f(500 + i);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("busy_in_reset", busy, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("busy_after_reset", busy, 0);
        chk("valid_after_reset", out_valid, 0);
        expect_rec(108, 17, 0);
        for (int i = 0; i < 8; i++) issue_f(10 + i);
        idle(6);
        drain("drain_t5");

        // Queue FULL, third frame completes on the same edge as a pop.
        do_reset();
        out_ready = 1'b0;
        expect_rec(800, 100, 0);
        expect_rec(1600, 200, 1);
        expect_rec(36, 8, 2);
        for (int i = 0; i < 8; i++) issue_f(100);
        for (int i = 0; i < 8; i++) issue_f(200);
        idle(6);
        for (int i = 0; i < 8; i++) issue_f(i + 1);
        idle(2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovf_push_pop_full", overflow, 0);
        chk("still_valid", out_valid, 1);
        chk("head_after_pop", out_frame_id, 1);
        out_ready = 1'b1;
        drain("drain_t6");
        chk("ovf_end_t6", overflow, 0);
        idle(3);
        chk("sb_empty_end", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
